// File: rtl/mem_access_unit.sv
// Memory stage: load/store lane steering, extension and req/ack sequencing.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning down.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [1:0]            ResultSrc_i,
    input  logic [1:0]            MemWrite_i,
    input  logic [2:0]            RegWrite_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stall_o,
    output logic [31:0]           rdata_o,
    output logic                  done_o,
    output logic                  err_o
);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  to_q, to_d;
    logic [2:0]            lt_q, lt_d;
    logic [1:0]            off_q, off_d;
    logic [7:0]            cnt_q, cnt_d;

    logic        is_store, is_load, is_byte, is_half, misal;
    logic [1:0]  off;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    // Store wins over load; off is the lane after aligning down to the access size.
    always_comb begin
        is_store = valid_i && (MemWrite_i != 2'b00);
        is_load  = valid_i && (ResultSrc_i == 2'b01);
        is_byte  = is_store ? (MemWrite_i == 2'b11)
                            : (RegWrite_i == 3'b011 || RegWrite_i == 3'b111);
        is_half  = is_store ? (MemWrite_i == 2'b10)
                            : (RegWrite_i == 3'b010 || RegWrite_i == 3'b110);
        off = 2'b00;
        if (is_byte) begin
            off = addr_i[1:0];
        end else if (is_half) begin
            off = {addr_i[1], 1'b0};
        end
        misal = (addr_i[1:0] != off);
    end

    always_comb begin
        ld_b = mem_rdata_i[{off_q, 3'b000} +: 8];
        ld_h = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        unique case (lt_q)
            3'b010:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b011:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b110:  ld_ext = {16'h0000, ld_h};
            3'b111:  ld_ext = {24'h000000, ld_b};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        to_d      = to_q;
        lt_d      = lt_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                to_d = 1'b0;
                if (is_store || is_load) begin
                    if (TRAP && misal) begin
                        err_o = 1'b1;
                        if (!is_store) begin
                            rdata_d = '0;
                        end
                    end else begin
                        stall_o = 1'b1;
                        addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        we_d    = is_store;
                        lt_d    = RegWrite_i;
                        off_d   = off;
                        cnt_d   = 8'(TIMEOUT_CYCLES);
                        state_d = REQ;
                        if (is_byte) begin
                            be_d    = 4'b0001 << off;
                            wdata_d = {4{wdata_i[7:0]}};
                        end else if (is_half) begin
                            be_d    = 4'b0011 << off;
                            wdata_d = {2{wdata_i[15:0]}};
                        end else begin
                            be_d    = 4'b1111;
                            wdata_d = wdata_i;
                        end
                    end
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                if (mem_ack_i) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                end else if (cnt_q <= 8'd1) begin
                    to_d    = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                done_o  = !to_q;
                err_o   = to_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
            lt_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            to_q    <= to_d;
            lt_q    <= lt_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_we_o    = we_q && (state_q == REQ);
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, timeout/reset sequences, random vs model.
// Assumes the default build (MEM_MISALIGN_TRAP_EN undefined).
module tb_mem_access_unit;
    logic        clk, rst_n, valid_i, mem_ack_i;
    logic [1:0]  ResultSrc_i, MemWrite_i;
    logic [2:0]  RegWrite_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;

    logic        d_req, d_we, d_stall, d_done, d_err;
    logic [31:0] d_addr, d_wd, d_rd;
    logic [3:0]  d_be;
    logic        t_req, t_we, t_stall, t_done, t_err;
    logic [31:0] t_addr, t_wd, t_rd;
    logic [3:0]  t_be;

    logic        sel_to;
    logic        o_req, o_we, o_stall, o_done, o_err;
    logic [31:0] o_addr, o_wd, o_rd;
    logic [3:0]  o_be;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
        .ResultSrc_i(ResultSrc_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(d_req), .mem_we_o(d_we), .mem_addr_o(d_addr),
        .mem_be_o(d_be), .mem_wdata_o(d_wd), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .stall_o(d_stall), .rdata_o(d_rd),
        .done_o(d_done), .err_o(d_err)
    );

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
        .ResultSrc_i(ResultSrc_i), .MemWrite_i(MemWrite_i),
        .RegWrite_i(RegWrite_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(t_req), .mem_we_o(t_we), .mem_addr_o(t_addr),
        .mem_be_o(t_be), .mem_wdata_o(t_wd), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .stall_o(t_stall), .rdata_o(t_rd),
        .done_o(t_done), .err_o(t_err)
    );

    assign o_req   = sel_to ? t_req   : d_req;
    assign o_we    = sel_to ? t_we    : d_we;
    assign o_stall = sel_to ? t_stall : d_stall;
    assign o_done  = sel_to ? t_done  : d_done;
    assign o_err   = sel_to ? t_err   : d_err;
    assign o_addr  = sel_to ? t_addr  : d_addr;
    assign o_wd    = sel_to ? t_wd    : d_wd;
    assign o_rd    = sel_to ? t_rd    : d_rd;
    assign o_be    = sel_to ? t_be    : d_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Results of the last transaction
    logic [31:0] r_addr, r_wd, r_rd;
    logic [3:0]  r_be;
    logic        r_we, r_stable, r_fin;
    int          r_nst, r_nreq, r_ndone, r_nerr, r_dcyc;

    task automatic do_access(input logic [1:0] rs, input logic [1:0] mw,
                             input logic [2:0] rw, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int dly);
        valid_i     = 1'b1;
        ResultSrc_i = rs;
        MemWrite_i  = mw;
        RegWrite_i  = rw;
        addr_i      = a;
        wdata_i     = wd;
        mem_rdata_i = rd;
        mem_ack_i   = 1'b0;
        r_nst = 0; r_nreq = 0; r_ndone = 0; r_nerr = 0; r_dcyc = -1;
        r_stable = 1'b1; r_fin = 1'b0;
        r_addr = '0; r_wd = '0; r_rd = '0; r_be = '0; r_we = 1'b0;
        for (int c = 0; c < 60 && !r_fin; c++) begin
            #1;
            if (o_stall) r_nst++;
            if (o_req) begin
                r_nreq++;
                if (r_nreq == 1) begin
                    r_addr = o_addr; r_be = o_be; r_wd = o_wd; r_we = o_we;
                end else if (o_addr !== r_addr || o_be !== r_be ||
                             o_wd !== r_wd || o_we !== r_we) begin
                    r_stable = 1'b0;
                end
            end
            if (o_done) r_ndone++;
            if (o_err) r_nerr++;
            if (o_done || o_err) begin
                r_fin  = 1'b1;
                r_dcyc = c;
                r_rd   = o_rd;
            end
            mem_ack_i = o_req && (r_nreq == dly + 1);
            @(negedge clk);
        end
        valid_i   = 1'b0;
        mem_ack_i = 1'b0;
        chk("complete", 32'(r_fin), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: kinds 0 sb,1 sh,2 sw,3 lb,4 lh,5 lw,6 lbu,7 lhu
    function automatic void model(input int k, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic [31:0] ea, output logic [3:0] ebe,
                                  output logic [31:0] ewd, output logic [31:0] erd);
        int size, off;
        logic [31:0] m, v;
        size = (k == 0 || k == 3 || k == 6) ? 1 :
               (k == 1 || k == 4 || k == 7) ? 2 : 4;
        off  = int'(a % 4);
        off  = off - off % size;
        ea   = a - (a % 4);
        ebe  = 4'(((1 << size) - 1) << off);
        ewd  = (size == 1) ? wd[7:0] * 32'h01010101 :
               (size == 2) ? wd[15:0] * 32'h00010001 : wd;
        m    = (size == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 32'd1;
        v    = (rd >> (8 * off)) & m;
        if ((k == 3 || k == 4) && v[8 * size - 1]) v = v | ~m;
        erd  = v;
    endfunction

    typedef struct {
        logic [1:0]  rs;
        logic [1:0]  mw;
        logic [2:0]  rw;
        logic [31:0] a, wd, rd;
        int          dly;
        logic [31:0] ea;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        ewe;
        logic [31:0] erd;
        bit          cbe, crd;
    } vec_t;

    vec_t        tv[12];
    logic [31:0] last_rd, exp_rd, ea, ewd, erd;
    logic [3:0]  ebe;
    logic [1:0]  mwc[3];
    logic [2:0]  rwc[5];

    initial begin
        tv[0]  = '{2'b00, 2'b11, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0,
                   32'h1000, 4'b1000, 32'hABABABAB, 1'b1, 32'h0, 1'b1, 1'b0};
        tv[1]  = '{2'b01, 2'b00, 3'b011, 32'h2002, 32'h0, 32'h0080FF11, 0,
                   32'h2000, 4'b0, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1};
        tv[2]  = '{2'b01, 2'b00, 3'b111, 32'h2002, 32'h0, 32'h0080FF11, 0,
                   32'h2000, 4'b0, 32'h0, 1'b0, 32'h00000080, 1'b0, 1'b1};
        tv[3]  = '{2'b01, 2'b00, 3'b110, 32'h2002, 32'h0, 32'h0080FF11, 0,
                   32'h2000, 4'b0, 32'h0, 1'b0, 32'h00000080, 1'b0, 1'b1};
        tv[4]  = '{2'b01, 2'b00, 3'b010, 32'h2000, 32'h0, 32'h0080FF11, 0,
                   32'h2000, 4'b0, 32'h0, 1'b0, 32'hFFFFFF11, 1'b0, 1'b1};
        tv[5]  = '{2'b01, 2'b00, 3'b001, 32'h4000, 32'h0, 32'hDEADBEEF, 5,
                   32'h4000, 4'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
        tv[6]  = '{2'b00, 2'b10, 3'b000, 32'h3002, 32'h00001234, 32'h0, 1,
                   32'h3000, 4'b1100, 32'h12341234, 1'b1, 32'h0, 1'b1, 1'b0};
        tv[7]  = '{2'b01, 2'b00, 3'b010, 32'h3001, 32'h0, 32'h00008001, 0,
                   32'h3000, 4'b0011, 32'h0, 1'b0, 32'hFFFF8001, 1'b1, 1'b1};
        tv[8]  = '{2'b00, 2'b01, 3'b000, 32'h5003, 32'hCAFEF00D, 32'h0, 2,
                   32'h5000, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1'b0};
        tv[9]  = '{2'b01, 2'b11, 3'b001, 32'h6001, 32'h0000005A, 32'hFFFFFFFF, 0,
                   32'h6000, 4'b0010, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b1, 1'b0};
        tv[10] = '{2'b01, 2'b00, 3'b000, 32'h6004, 32'h0, 32'h11223344, 3,
                   32'h6004, 4'b0, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b1};
        tv[11] = '{2'b01, 2'b00, 3'b010, 32'h7002, 32'h0, 32'h7FFF0000, 0,
                   32'h7000, 4'b0, 32'h0, 1'b0, 32'h00007FFF, 1'b0, 1'b1};
        mwc = '{2'b11, 2'b10, 2'b01};
        rwc = '{3'b011, 3'b010, 3'b001, 3'b111, 3'b110};

        rst_n = 1'b0; valid_i = 1'b0; mem_ack_i = 1'b0; sel_to = 1'b0;
        ResultSrc_i = '0; MemWrite_i = '0; RegWrite_i = '0;
        addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst req", 32'(o_req), 32'd0);
        chk("rst we", 32'(o_we), 32'd0);
        chk("rst stall", 32'(o_stall), 32'd0);
        chk("rst done", 32'(o_done), 32'd0);
        chk("rst err", 32'(o_err), 32'd0);
        chk("rst addr", o_addr, 32'h0);
        chk("rst be", 32'(o_be), 32'h0);
        chk("rst wdata", o_wd, 32'h0);
        chk("rst rdata", o_rd, 32'h0);
        @(negedge clk);

        last_rd = '0;
        for (int i = 0; i < 12; i++) begin
            do_access(tv[i].rs, tv[i].mw, tv[i].rw, tv[i].a, tv[i].wd,
                      tv[i].rd, tv[i].dly);
            exp_rd  = tv[i].crd ? tv[i].erd : last_rd;
            last_rd = exp_rd;
            chk($sformatf("v%0d addr", i), r_addr, tv[i].ea);
            chk($sformatf("v%0d we", i), 32'(r_we), 32'(tv[i].ewe));
            if (tv[i].cbe) chk($sformatf("v%0d be", i), 32'(r_be), 32'(tv[i].ebe));
            if (tv[i].ewe) chk($sformatf("v%0d wdata", i), r_wd, tv[i].ewd);
            chk($sformatf("v%0d rdata", i), r_rd, exp_rd);
            chk($sformatf("v%0d nreq", i), 32'(r_nreq), 32'(tv[i].dly + 1));
            chk($sformatf("v%0d nstall", i), 32'(r_nst), 32'(tv[i].dly + 2));
            chk($sformatf("v%0d done cyc", i), 32'(r_dcyc), 32'(tv[i].dly + 2));
            chk($sformatf("v%0d ndone", i), 32'(r_ndone), 32'd1);
            chk($sformatf("v%0d nerr", i), 32'(r_nerr), 32'd0);
            chk($sformatf("v%0d stable", i), 32'(r_stable), 32'd1);
        end

        // Timeout on the 4-cycle instance, then a normal access
        do_reset();
        sel_to = 1'b1;
        do_access(2'b00, 2'b01, 3'b000, 32'h8000, 32'h1, 32'h0, 1000);
        chk("to nerr", 32'(r_nerr), 32'd1);
        chk("to ndone", 32'(r_ndone), 32'd0);
        chk("to nreq", 32'(r_nreq), 32'd4);
        chk("to nstall", 32'(r_nst), 32'd5);
        chk("to err cyc", 32'(r_dcyc), 32'd5);
        chk("to rdata", r_rd, 32'h0);
        #1;
        chk("to idle stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        do_access(2'b01, 2'b00, 3'b001, 32'h8004, 32'h0, 32'h000055AA, 0);
        chk("to next done", 32'(r_ndone), 32'd1);
        chk("to next err", 32'(r_nerr), 32'd0);
        chk("to next rdata", r_rd, 32'h000055AA);
        sel_to = 1'b0;

        // Reset while in REQ with an ack arriving the same cycle
        do_reset();
        do_access(2'b01, 2'b00, 3'b001, 32'h9000, 32'h0, 32'hA5A5A5A5, 0);
        chk("pre rdata", r_rd, 32'hA5A5A5A5);
        valid_i = 1'b1; ResultSrc_i = 2'b01; MemWrite_i = 2'b00;
        RegWrite_i = 3'b001; addr_i = 32'h9004; mem_rdata_i = 32'h12345678;
        #1;
        chk("ar idle stall", 32'(o_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("ar in req", 32'(o_req), 32'd1);
        mem_ack_i = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        chk("ar req", 32'(o_req), 32'd0);
        chk("ar done", 32'(o_done), 32'd0);
        chk("ar stall", 32'(o_stall), 32'd0);
        chk("ar rdata", o_rd, 32'h0);
        chk("ar addr", o_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("ar done2", 32'(o_done), 32'd0);
        @(negedge clk);

        // Random accesses against the reference model
        last_rd = '0;
        for (int n = 0; n < 150; n++) begin
            int          k, dly;
            logic [31:0] a, wd, rd;
            logic [1:0]  rs, mw;
            logic [2:0]  rw;
            k   = $urandom_range(0, 7);
            dly = $urandom_range(0, 3);
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            if (k < 3) begin
                rs = 2'b00; mw = mwc[k]; rw = 3'($urandom);
            end else begin
                rs = 2'b01; mw = 2'b00; rw = rwc[k - 3];
            end
            model(k, a, wd, rd, ea, ebe, ewd, erd);
            if (k >= 3) last_rd = erd;
            do_access(rs, mw, rw, a, wd, rd, dly);
            chk($sformatf("r%0d addr", n), r_addr, ea);
            chk($sformatf("r%0d we", n), 32'(r_we), 32'(k < 3));
            if (k < 3) begin
                chk($sformatf("r%0d be", n), 32'(r_be), 32'(ebe));
                chk($sformatf("r%0d wdata", n), r_wd, ewd);
            end
            chk($sformatf("r%0d rdata", n), r_rd, last_rd);
            chk($sformatf("r%0d nstall", n), 32'(r_nst), 32'(dly + 2));
            chk($sformatf("r%0d ndone", n), 32'(r_ndone), 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                mem_ack_i = 1'b1;
                #1;
                chk($sformatf("r%0d stray ack", n), 32'(o_done | o_stall), 32'd0);
                @(negedge clk);
                mem_ack_i = 1'b0;
                #1;
                chk($sformatf("r%0d stray ack2", n), 32'(o_done | o_req), 32'd0);
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the pipelined RV32I core.
- Consumes the decoded ResultSrc, MemWrite and RegWrite codes carried down from decode, plus the ALU address and store data.
- Runs a request/acknowledge transaction with data memory.
- Produces a byte-lane-aligned store, a sign- or zero-extended load result, and a pipeline stall while the access is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width of addr_i and mem_addr_o.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack_i before aborting with err_o (range 1..255).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- valid_i  input  1  memory-stage instruction valid
- ResultSrc_i  input  2  decoded result select; 01 = load
- MemWrite_i  input  2  00 none, 01 sw, 10 sh, 11 sb
- RegWrite_i  input  3  load type when ResultSrc_i=01: 001 lw, 010 lh, 011 lb, 110 lhu, 111 lbu
- addr_i  input  ADDR_WIDTH  ALU result (byte address)
- wdata_i  input  32  rs2 store data
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write
- mem_addr_o  output  ADDR_WIDTH  word-aligned address (bits [1:0]=00)
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  32  lane-shifted store data
- mem_rdata_i  input  32  memory read word
- mem_ack_i  input  1  memory completion, valid only while mem_req_o=1
- stall_o  output  1  freeze upstream stages
- rdata_o  output  32  extended load result
- done_o  output  1  one-cycle pulse: access completed
- err_o  output  1  one-cycle pulse: misalign or timeout

Behaviour:
- Reset (rst_n=0 at rising clk): FSM=IDLE. mem_req_o, mem_we_o, stall_o, done_o, err_o = 0. mem_addr_o, mem_be_o, mem_wdata_o, rdata_o = 0. Timeout counter = 0.
- Access classification:
  - A load is valid_i & ResultSrc_i==01.
  - A store is valid_i & MemWrite_i!=00.
  - Both true at once: the store wins.
  - Neither: the block is transparent, stall_o=0, no memory activity.
- Alignment: sw/lw need addr[1:0]=00; sh/lh/lhu need addr[0]=0; byte accesses are always aligned.
- Store lanes: sb gives be=0001<<addr[1:0], with wdata[7:0] replicated to all four lanes. sh gives be=0011<<addr[1:0], with wdata[15:0] replicated to both halves. sw gives be=1111 and wdata unchanged.
- Load extract: select the byte or half from mem_rdata_i by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word. Any other RegWrite_i code with ResultSrc_i=01 is treated as lw.
- FSM states IDLE, REQ, RESP:
  - IDLE: when an aligned access is presented, stall_o=1 combinationally. At the clock edge, latch addr, be, wdata, we and load type, load the timeout counter, then go to REQ.
  - REQ: mem_req_o=1, stall_o=1, outputs stable and held from the latches. The counter decrements each cycle.
    - mem_ack_i=1: go to RESP, registering the extended rdata_o (loads) or leaving rdata_o unchanged (stores).
    - Counter reaches 0 without ack: pulse err_o, go to RESP, rdata_o=0.
  - RESP: done_o=1 (unless timed out), stall_o=0, mem_req_o=0. Next cycle goes to IDLE.
    - Upstream advances on this cycle, so the RESP cycle's valid_i belongs to the same instruction and must not start a new access.
    - A new access is accepted only from IDLE on the following cycle.
- Latency: request visible 1 cycle after acceptance. With 0-wait memory (ack in the first REQ cycle), rdata_o/done_o appear 2 cycles after acceptance and the stall lasts exactly 2 cycles.
- mem_ack_i outside REQ is ignored.
- rst_n low in REQ or RESP aborts immediately: the next cycle is IDLE with all outputs at reset values and no done_o.
- rdata_o holds its last value until the next completed load.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access pulses err_o for one cycle in IDLE, stall_o stays 0, and no request is issued.
  - Loads return rdata_o=0.
- Undefined:
  - Misaligned addresses are aligned down (lw/sw clear bits [1:0], halfword accesses clear bit 0) and proceed normally.
  - err_o is asserted only on timeout.

Test Plan:
- sb, addr=0x1003, wdata=0x000000AB, ack in first REQ cycle -> mem_addr_o=0x1000, be=1000, mem_wdata_o=0xABABABAB, mem_we_o=1, done_o at cycle+2, stall_o high 2 cycles.
- lb, addr=0x2002, mem_rdata_i=0x0080FF11 -> rdata_o=0xFFFFFF80. Same address with lbu -> 0x00000080. lhu at 0x2002 -> 0x00000080. lh at 0x2000 -> 0xFFFFFF11.
- lw with ack delayed 5 cycles -> mem_req_o held 6 cycles with stable address, stall_o high 7 cycles, single done_o pulse.
- sw, TIMEOUT_CYCLES=4, ack never asserted -> err_o pulse after 4 REQ cycles, no done_o, return to IDLE, next access accepted.
- lh at 0x3001 -> with MEM_MISALIGN_TRAP_EN: err_o pulse, no mem_req_o, rdata_o=0. Without: access issued at 0x3000 with be=0011.
- rst_n driven low during REQ with an ack arriving the same cycle -> next cycle IDLE, mem_req_o=0, no done_o, rdata_o=0.
